// File: rtl/spi_wstat_pkg.sv
// Shared types and constants for the SPI write-status buffer.
package spi_wstat_pkg;

  // Status codes; any non-zero code counts as an error
  localparam logic [2:0] ST_OK     = 3'b000;
  localparam logic [2:0] ST_SLVERR = 3'b001;
  localparam logic [2:0] ST_DECERR = 3'b010;

  // Entry field widths
  localparam int unsigned ST_W    = 3;
  localparam int unsigned LAST_W  = 1;
  localparam int unsigned ID_W    = 4;
  localparam int unsigned MSTID_W = 8;

  // Entry field offsets (LSB position within the packed entry)
  localparam int unsigned MSTID_OFF = 0;
  localparam int unsigned ID_OFF    = MSTID_OFF + MSTID_W;
  localparam int unsigned LAST_OFF  = ID_OFF + ID_W;
  localparam int unsigned ST_OFF    = LAST_OFF + LAST_W;

  localparam int unsigned ENTRY_W = 16;

  // One buffered status beat, MSB first: status, last, id, mstid
  typedef struct packed {
    logic [ST_W-1:0]    status;
    logic               last;
    logic [ID_W-1:0]    id;
    logic [MSTID_W-1:0] mstid;
  } entry_t;

  // True for any status code other than OK
  function automatic logic is_err(input logic [ST_W-1:0] st);
    return st != ST_OK;
  endfunction

endpackage

// File: rtl/spi_wstat_fifo.sv
// Generic synchronous FIFO with registered occupancy; head word read from storage.
module spi_wstat_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;

  logic w_push;
  logic w_pop;

  // Status flags come only from the registered level
  assign o_full  = (r_level == LVL_W'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_data  = r_mem[r_rd_ptr];

  // Guard against overflow/underflow regardless of caller
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Storage write; cleared on reset so the head reads zero when empty after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  // Occupancy tracking; simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/spi_wstat_buf.sv
// Write-status buffer between the SPI slave CBUS port and the fabric status channel,
// with a saturating error counter and per-error interrupt pulse.
module spi_wstat_buf
  import spi_wstat_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ERRCNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sreq,
  input  logic [2:0]              sstatus,
  input  logic                    sdone,
  input  logic [3:0]              sid,
  input  logic [7:0]              smstid,
  output logic                    sready,
  output logic                    wst_valid,
  output logic [2:0]              wst_status,
  output logic                    wst_last,
  output logic [3:0]              wst_id,
  output logic [7:0]              wst_mstid,
  input  logic                    wst_ready,
  input  logic                    err_clr,
  output logic [ERRCNT_W-1:0]     err_cnt,
  output logic                    err_irq,
  output logic [$clog2(DEPTH):0]  level
);

  entry_t               w_push_entry;
  logic [ENTRY_W-1:0]   w_head;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_err_push;

  logic [ERRCNT_W-1:0]  r_err_cnt;
  logic                 r_err_irq;

  // Handshake mapping: both flags depend only on stored occupancy
  assign sready    = !w_full;
  assign wst_valid = !w_empty;
  assign w_push    = sreq && sready;
  assign w_pop     = wst_valid && wst_ready;

  // Pack incoming beat
  always_comb begin
    w_push_entry        = '0;
    w_push_entry.status = sstatus;
    w_push_entry.last   = sdone;
    w_push_entry.id     = sid;
    w_push_entry.mstid  = smstid;
  end

  spi_wstat_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_entry),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  // Head entry unpacked onto the fabric status channel
  assign wst_status = w_head[ST_OFF +: ST_W];
  assign wst_last   = w_head[LAST_OFF];
  assign wst_id     = w_head[ID_OFF +: ID_W];
  assign wst_mstid  = w_head[MSTID_OFF +: MSTID_W];

  // Errors are accounted at acceptance time
  assign w_err_push = w_push && is_err(sstatus);

  // Saturating error counter; a clear still counts a coincident error beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (err_clr) begin
      r_err_cnt <= ERRCNT_W'(w_err_push);
    end else if (w_err_push && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ERRCNT_W'(1);
    end
  end

  // One-cycle interrupt pulse per accepted error beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_irq <= 1'b0;
    end else begin
      r_err_irq <= w_err_push;
    end
  end

  assign err_cnt = r_err_cnt;
  assign err_irq = r_err_irq;

endmodule
